// File: rtl/usb_rx_bit_unstuffer_if.sv
// Purpose: bundles the NRZ bit input and the byte/status outputs of the USB RX unstuffer.
// Latency: none (wiring only).
// Backpressure: none; the receive stream is paced by i_valid and cannot be stalled.
interface usb_rx_bit_unstuffer_if;
    logic       i_data;
    logic       i_valid;
    logic       i_start;
    logic       i_eop;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       o_stuff_err;
    logic       o_eop;
    logic       o_align_err;
    logic       o_active;

    // Producer side: NRZI decoder / packet-layer testbench
    modport master (
        output i_data, i_valid, i_start, i_eop,
        input  o_byte, o_byte_valid, o_stuff_err, o_eop, o_align_err, o_active
    );

    // Unstuffer side
    modport slave (
        input  i_data, i_valid, i_start, i_eop,
        output o_byte, o_byte_valid, o_stuff_err, o_eop, o_align_err, o_active
    );
endinterface

// File: rtl/usb_rx_bit_unstuffer.sv
// Purpose: drops stuffed zeros from the NRZ stream, flags stuff violations, packs bytes LSB-first.
// Latency: all outputs registered; byte/stuff/eop strobes one cycle after the causing input.
// Backpressure: none; bits are consumed only when i_valid is high, gaps hold all state.
module usb_rx_bit_unstuffer #(
    parameter int STUFF_LEN = 6,
    parameter int SYNC_ONES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    usb_rx_bit_unstuffer_if.slave bus
);
    localparam int OW = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, SKIP, ERR} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   ones_cnt_q, ones_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_valid_q, byte_valid_d;
    logic            stuff_err_q, stuff_err_d;
    logic            eop_q, eop_d;
    logic            align_err_q, align_err_d;

    logic [OW-1:0]   ones_inc;
    logic [7:0]      shift_in;

    assign ones_inc = ones_cnt_q + OW'(1);
    assign shift_in = {bus.i_data, shift_q[7:1]};

    // Next state: bit processing first, then end-of-packet, then start (start wins on the state).
    always_comb begin
        state_d      = state_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        stuff_err_d  = 1'b0;
        eop_d        = 1'b0;
        align_err_d  = 1'b0;

        // A bit arriving with i_start is the tail of SYNC and is never data.
        if (bus.i_valid && !bus.i_start) begin
            case (state_q)
                RUN: begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_d       = shift_in;
                        byte_valid_d = 1'b1;
                    end
                    if (bus.i_data) begin
                        ones_cnt_d = ones_inc;
                        if (ones_inc == OW'(STUFF_LEN)) begin
                            state_d = SKIP;
                        end
                    end else begin
                        ones_cnt_d = '0;
                    end
                end
                SKIP: begin
                    if (!bus.i_data) begin
                        ones_cnt_d = '0;
                        state_d    = RUN;
                    end else begin
                        stuff_err_d = 1'b1;
                        state_d     = ERR;
                    end
                end
                default: ;
            endcase
        end

        // Alignment is judged on the post-bit position, so a byte finished by the
        // same-cycle bit ends cleanly; once in ERR the byte position is meaningless.
        if (bus.i_eop) begin
            eop_d = 1'b1;
            if (state_q != IDLE) begin
                align_err_d = (state_d != ERR) && (bit_cnt_d != 3'd0);
                state_d     = IDLE;
                ones_cnt_d  = '0;
                bit_cnt_d   = '0;
                shift_d     = '0;
            end
        end

        // Arm (or re-arm, dropping any partial byte); SYNC's trailing ones count toward stuffing.
        if (bus.i_start) begin
            state_d    = RUN;
            ones_cnt_d = OW'(SYNC_ONES);
            bit_cnt_d  = '0;
            shift_d    = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            ones_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
            eop_q        <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            stuff_err_q  <= stuff_err_d;
            eop_q        <= eop_d;
            align_err_q  <= align_err_d;
        end
    end

    assign bus.o_byte       = byte_q;
    assign bus.o_byte_valid = byte_valid_q;
    assign bus.o_stuff_err  = stuff_err_q;
    assign bus.o_eop        = eop_q;
    assign bus.o_align_err  = align_err_q;
    assign bus.o_active     = (state_q != IDLE);
endmodule
